// File: rtl/mio_arb_pkg.sv
// Shared constants for the memory/IO bus arbiter: state encodings,
// one-hot grant codes and the default abort threshold.
package mio_arb_pkg;

    // Sequencer states; 2'b11 is unused and treated as illegal.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // One-hot owner codes driven on grant.
    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    // BUSY cycles without an acknowledge before the transaction is aborted.
    localparam int TIMEOUT_DEFAULT = 255;

    // Width of the saturating timeout counter.
    localparam int CNT_W = 16;

endpackage

// File: rtl/mio_arbiter.sv
// Two-port arbiter and sequencer for the shared memory/IO bus.
// Handshake: a master raises mX_req with we/addr/wdata and holds it until it
// sees the one-cycle mX_ready pulse; the request is then considered consumed.
// On the bus side mem_req stays high with stable mem_we/addr/wdata until a
// one-cycle mem_ack arrives or the timeout aborts the transfer.
module mio_arbiter
    import mio_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          bus_err,
    output logic [1:0]    grant,
    output logic [1:0]    state_out
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    // Registered state and outputs
    state_e           r_state;
    logic             r_last_grant;   // 1 = m1 was served last
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;
    logic [DW-1:0]    r_m0_rdata;
    logic [DW-1:0]    r_m1_rdata;
    logic             r_m0_ready;
    logic             r_m1_ready;
    logic             r_bus_err;
    logic [1:0]       r_grant;

    // Next-state values
    state_e           w_state_next;
    logic             w_last_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_mem_req_next;
    logic             w_mem_we_next;
    logic [AW-1:0]    w_mem_addr_next;
    logic [DW-1:0]    w_mem_wdata_next;
    logic [DW-1:0]    w_m0_rdata_next;
    logic [DW-1:0]    w_m1_rdata_next;
    logic             w_m0_ready_next;
    logic             w_m1_ready_next;
    logic             w_bus_err_next;
    logic [1:0]       w_grant_next;

    // Arbitration and counter helpers
    logic             w_any_req;
    logic             w_pick_m1;
    logic [CNT_W-1:0] w_cnt_inc;

    // Round-robin pick: a lone requester wins; on a tie the port not served last wins.
    always_comb begin
        w_any_req = m0_req | m1_req;
        w_pick_m1 = m1_req & (~m0_req | ~r_last_grant);
        w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    end

    // Next-state and output decode for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        w_state_next     = r_state;
        w_last_next      = r_last_grant;
        w_cnt_next       = r_cnt;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        w_m0_rdata_next  = r_m0_rdata;
        w_m1_rdata_next  = r_m1_rdata;
        w_m0_ready_next  = r_m0_ready;
        w_m1_ready_next  = r_m1_ready;
        w_bus_err_next   = r_bus_err;
        w_grant_next     = r_grant;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_mem_req_next   = 1'b1;
                    w_grant_next     = w_pick_m1 ? GRANT_M1 : GRANT_M0;
                    w_last_next      = w_pick_m1;
                    w_cnt_next       = '0;
                    w_mem_we_next    = w_pick_m1 ? m1_we    : m0_we;
                    w_mem_addr_next  = w_pick_m1 ? m1_addr  : m0_addr;
                    w_mem_wdata_next = w_pick_m1 ? m1_wdata : m0_wdata;
                    w_state_next     = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (mem_ack) begin
                    // Acknowledge wins even on the cycle the timeout would fire.
                    w_mem_req_next = 1'b0;
                    if (r_grant[1]) begin
                        w_m1_ready_next = 1'b1;
                        if (!r_mem_we) w_m1_rdata_next = mem_rdata;
                    end else begin
                        w_m0_ready_next = 1'b1;
                        if (!r_mem_we) w_m0_rdata_next = mem_rdata;
                    end
                    w_state_next = ST_DONE;
                end else begin
                    w_cnt_next = w_cnt_inc;
                    if (w_cnt_inc == TO_CNT) begin
                        // Abort: complete the requester with an error, keep its rdata.
                        w_mem_req_next = 1'b0;
                        w_bus_err_next = 1'b1;
                        if (r_grant[1]) w_m1_ready_next = 1'b1;
                        else            w_m0_ready_next = 1'b1;
                        w_state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // Requests are ignored here: the owner still holds req during its ready cycle.
                w_m0_ready_next = 1'b0;
                w_m1_ready_next = 1'b0;
                w_bus_err_next  = 1'b0;
                w_grant_next    = GRANT_NONE;
                w_state_next    = ST_IDLE;
            end

            default: begin
                w_state_next     = ST_IDLE;
                w_cnt_next       = '0;
                w_mem_req_next   = 1'b0;
                w_mem_we_next    = 1'b0;
                w_mem_addr_next  = '0;
                w_mem_wdata_next = '0;
                w_m0_rdata_next  = '0;
                w_m1_rdata_next  = '0;
                w_m0_ready_next  = 1'b0;
                w_m1_ready_next  = 1'b0;
                w_bus_err_next   = 1'b0;
                w_grant_next     = GRANT_NONE;
            end
        endcase
    end

    // State and output registers; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
            r_m0_ready   <= 1'b0;
            r_m1_ready   <= 1'b0;
            r_bus_err    <= 1'b0;
            r_grant      <= GRANT_NONE;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_next;
            r_cnt        <= w_cnt_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_m0_rdata   <= w_m0_rdata_next;
            r_m1_rdata   <= w_m1_rdata_next;
            r_m0_ready   <= w_m0_ready_next;
            r_m1_ready   <= w_m1_ready_next;
            r_bus_err    <= w_bus_err_next;
            r_grant      <= w_grant_next;
        end
    end

    assign m0_rdata  = r_m0_rdata;
    assign m0_ready  = r_m0_ready;
    assign m1_rdata  = r_m1_rdata;
    assign m1_ready  = r_m1_ready;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign bus_err   = r_bus_err;
    assign grant     = r_grant;
    assign state_out = r_state;

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed cycle/data expectations.
module tb_mio_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    // ---------------- clock / reset ----------------
    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT connections ----------------
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m0_ready, m1_ready;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          bus_err;
    logic [1:0]    grant;
    logic [1:0]    state_out;

    logic          auto_ack = 1'b0;
    logic          spur_ack = 1'b0;
    logic [DW-1:0] resp_data = '0;
    int            ack_delay = -1;
    int            resp_cnt  = 0;

    assign mem_ack   = auto_ack | spur_ack;
    assign mem_rdata = resp_data;

    mio_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err), .grant(grant), .state_out(state_out)
    );

    // ---------------- counters ----------------
    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bus responder: ack after ack_delay cycles of mem_req ----------------
    always @(negedge clk) begin
        if (!reset_n || !mem_req) begin
            resp_cnt = 0;
            auto_ack = 1'b0;
        end else begin
            auto_ack = (ack_delay >= 0) && (resp_cnt == ack_delay);
            resp_cnt++;
        end
    end

    // ---------------- reference model (transaction level) ----------------
    // owner = -1 when no transaction is open; done marks the completion cycle.
    int            m_owner  = -1;
    bit            m_done   = 1'b0;
    int            m_last   = 1;
    int            m_cyc    = 0;
    int            m_t_grant = 0;
    logic          m_we     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wdata  = '0;
    logic          m_ready [2] = '{1'b0, 1'b0};
    logic [DW-1:0] m_rdata [2] = '{'0, '0};
    logic          m_err    = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_owner = -1; m_done = 1'b0; m_last = 1; m_cyc = 0; m_t_grant = 0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0;
            m_ready[0] = 1'b0; m_ready[1] = 1'b0;
            m_rdata[0] = '0;   m_rdata[1] = '0;
            m_err = 1'b0;
        end else begin
            m_cyc++;
            if (m_done) begin
                m_done = 1'b0; m_owner = -1;
                m_ready[0] = 1'b0; m_ready[1] = 1'b0; m_err = 1'b0;
            end else if (m_owner < 0) begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) m_owner = 1 - m_last;
                    else                  m_owner = m0_req ? 0 : 1;
                    m_last    = m_owner;
                    m_t_grant = m_cyc;
                    m_we      = (m_owner == 0) ? m0_we    : m1_we;
                    m_addr    = (m_owner == 0) ? m0_addr  : m1_addr;
                    m_wdata   = (m_owner == 0) ? m0_wdata : m1_wdata;
                end
            end else begin
                if (mem_ack) begin
                    m_ready[m_owner] = 1'b1;
                    if (!m_we) m_rdata[m_owner] = mem_rdata;
                    m_done = 1'b1;
                end else if (m_cyc - m_t_grant == TO) begin
                    m_ready[m_owner] = 1'b1;
                    m_err  = 1'b1;
                    m_done = 1'b1;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic       e_mem_req;
        logic [1:0] e_grant;
        logic [1:0] e_state;
        if (chk_on) begin
            e_mem_req = (m_owner >= 0) && !m_done;
            e_grant   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
            e_state   = m_done ? 2'b10 : (m_owner >= 0) ? 2'b01 : 2'b00;
            chk("mem_req",   64'(mem_req),   64'(e_mem_req));
            chk("grant",     64'(grant),     64'(e_grant));
            chk("state_out", 64'(state_out), 64'(e_state));
            chk("m0_ready",  64'(m0_ready),  64'(m_ready[0]));
            chk("m1_ready",  64'(m1_ready),  64'(m_ready[1]));
            chk("bus_err",   64'(bus_err),   64'(m_err));
            chk("m0_rdata",  64'(m0_rdata),  64'(m_rdata[0]));
            chk("m1_rdata",  64'(m1_rdata),  64'(m_rdata[1]));
            chk("mem_we",    64'(mem_we),    64'(m_we));
            chk("mem_addr",  64'(mem_addr),  64'(m_addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
    end

    // ---------------- activity monitor ----------------
    int         mreq_cnt = 0, rdy0_cnt = 0, rdy1_cnt = 0, err_cnt = 0;
    logic [1:0] grant_or = 2'b00;

    always @(negedge clk) begin
        if (mem_req) begin
            mreq_cnt++;
            grant_or = grant_or | grant;
        end
        if (m0_ready) rdy0_cnt++;
        if (m1_ready) rdy1_cnt++;
        if (bus_err)  err_cnt++;
    end

    task automatic clr_mon();
        mreq_cnt = 0; rdy0_cnt = 0; rdy1_cnt = 0; err_cnt = 0; grant_or = 2'b00;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Wait (bounded) for a ready pulse on one port; returns the cycle index.
    task automatic wait_ready(input string name, input int port, input int budget,
                              output int at, output logic err);
        at  = -1;
        err = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if ((port == 0) ? m0_ready : m1_ready) begin
                at  = c;
                err = bus_err;
                break;
            end
        end
        if (at < 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no ready on port %0d within %0d cycles", name, port, budget);
        end
    endtask

    // ---------------- scoreboard for arbitration order ----------------
    logic [7:0] exp_q[$];   // {port, completion cycle[6:0]}

    // ---------------- watchdog ----------------
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         at;
        logic       err;
        int         n0, n1;
        logic [7:0] ev;
        logic [7:0] want;

        #1 chk_on = 1'b1;

        // Reset values
        @(negedge clk);
        chk("rst_mem_req",   64'(mem_req),   64'(0));
        chk("rst_grant",     64'(grant),     64'(0));
        chk("rst_state",     64'(state_out), 64'(0));
        chk("rst_m0_rdata",  64'(m0_rdata),  64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        // T1: m0 read alone, ack in cycle 3 -> ready in cycle 4
        clr_mon();
        ack_delay = 2; resp_data = 32'h1234_5678;
        m0_we = 1'b0; m0_addr = 32'h0000_0040; m0_req = 1'b1;
        wait_ready("t1_wait", 0, 10, at, err);
        chk("t1_ready_cycle", 64'(at), 64'(4));
        chk("t1_bus_err",     64'(err), 64'(0));
        chk("t1_m0_rdata",    64'(m0_rdata), 64'(32'h1234_5678));
        m0_req = 1'b0;
        @(negedge clk);
        chk("t1_mreq_cycles", 64'(mreq_cnt), 64'(3));
        chk("t1_grant_busy",  64'(grant_or), 64'(2'b01));
        chk("t1_m1_ready",    64'(rdy1_cnt), 64'(0));
        chk("t1_idle",        64'(state_out), 64'(0));

        // T3: timeout, no ack -> mem_req 4 cycles, ready+bus_err in cycle 5
        clr_mon();
        ack_delay = -1; resp_data = 32'hFFFF_0000;
        m0_addr = 32'h0000_0300; m0_req = 1'b1;
        wait_ready("t3_wait", 0, 20, at, err);
        chk("t3_ready_cycle", 64'(at), 64'(TO + 1));
        chk("t3_bus_err",     64'(err), 64'(1));
        chk("t3_rdata_kept",  64'(m0_rdata), 64'(32'h1234_5678));
        m0_req = 1'b0;
        @(negedge clk);
        chk("t3_mreq_cycles", 64'(mreq_cnt), 64'(4));
        chk("t3_err_pulses",  64'(err_cnt), 64'(1));

        // T3b: next transaction succeeds
        clr_mon();
        ack_delay = 1; resp_data = 32'hCAFE_F00D;
        m0_addr = 32'h0000_0304; m0_req = 1'b1;
        wait_ready("t3b_wait", 0, 10, at, err);
        chk("t3b_ready_cycle", 64'(at), 64'(3));
        chk("t3b_bus_err",     64'(err), 64'(0));
        chk("t3b_m0_rdata",    64'(m0_rdata), 64'(32'hCAFE_F00D));
        m0_req = 1'b0;
        @(negedge clk);

        // T4: ack on the exact timeout cycle -> success
        clr_mon();
        ack_delay = TO - 1; resp_data = 32'h0BAD_BEEF;
        m0_addr = 32'h0000_0308; m0_req = 1'b1;
        wait_ready("t4_wait", 0, 10, at, err);
        chk("t4_ready_cycle", 64'(at), 64'(5));
        chk("t4_bus_err",     64'(err), 64'(0));
        chk("t4_m0_rdata",    64'(m0_rdata), 64'(32'h0BAD_BEEF));
        m0_req = 1'b0;
        @(negedge clk);
        chk("t4_err_pulses",  64'(err_cnt), 64'(0));

        // T5a: spurious ack in IDLE
        clr_mon();
        resp_data = 32'hDEAD_DEAD; spur_ack = 1'b1;
        repeat (3) @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        chk("t5a_no_ready",  64'(rdy0_cnt + rdy1_cnt), 64'(0));
        chk("t5a_rdata",     64'(m0_rdata), 64'(32'h0BAD_BEEF));

        // T5b: spurious ack in DONE
        clr_mon();
        ack_delay = 0; resp_data = 32'h0102_0304;
        m0_addr = 32'h0000_030C; m0_req = 1'b1;
        wait_ready("t5b_wait", 0, 10, at, err);
        chk("t5b_ready_cycle", 64'(at), 64'(2));
        resp_data = 32'hDEAD_DEAD; spur_ack = 1'b1; m0_req = 1'b0;
        @(negedge clk);
        spur_ack = 1'b0;
        @(negedge clk);
        chk("t5b_rdata",     64'(m0_rdata), 64'(32'h0102_0304));
        chk("t5b_ready_cnt", 64'(rdy0_cnt), 64'(1));

        // T5c: m1 write, inputs changed mid-BUSY must not reach the bus
        ack_delay = 3;
        m1_we = 1'b1; m1_addr = 32'h0000_0400; m1_wdata = 32'h1111_2222; m1_req = 1'b1;
        repeat (2) @(negedge clk);
        m1_we = 1'b0; m1_addr = 32'h0000_04FC; m1_wdata = 32'h9999_8888;
        @(negedge clk);
        chk("t5c_mem_addr",  64'(mem_addr),  64'(32'h0000_0400));
        chk("t5c_mem_wdata", 64'(mem_wdata), 64'(32'h1111_2222));
        chk("t5c_mem_we",    64'(mem_we),    64'(1));
        wait_ready("t5c_wait", 1, 10, at, err);
        chk("t5c_ready_cycle", 64'(at), 64'(2));
        m1_req = 1'b0;
        @(negedge clk);
        chk("t5c_m1_rdata",  64'(m1_rdata), 64'(0));

        // T6: reset asserted mid-BUSY, pending m1 granted after release
        ack_delay = -1;
        m1_we = 1'b0; m1_addr = 32'h0000_0500; m1_req = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_mem_req_drop", 64'(mem_req),   64'(0));
        chk("t6_grant_drop",   64'(grant),     64'(0));
        chk("t6_state",        64'(state_out), 64'(0));
        chk("t6_m0_rdata_clr", 64'(m0_rdata),  64'(0));
        ack_delay = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_grant_m1",     64'(grant), 64'(2'b10));
        wait_ready("t6_wait", 1, 10, at, err);
        chk("t6_ready_cycle",  64'(at), 64'(1));
        m1_req = 1'b0;
        @(negedge clk);

        // T2: both request after reset, held back-to-back -> m0,m1,m0,m1
        do_reset();
        clr_mon();
        ack_delay = 0; resp_data = 32'h600D_600D;
        m0_we = 1'b1; m0_addr = 32'h0000_0600; m0_wdata = 32'hA5A5_A5A5;
        m1_we = 1'b0; m1_addr = 32'h0000_0700;
        exp_q.push_back(8'h02);   // m0 at cycle 2
        exp_q.push_back(8'h85);   // m1 at cycle 5
        exp_q.push_back(8'h08);   // m0 at cycle 8
        exp_q.push_back(8'h8B);   // m1 at cycle 11
        m0_req = 1'b1; m1_req = 1'b1;
        n0 = 0; n1 = 0;
        for (int c = 1; c <= 30 && (n0 < 2 || n1 < 2); c++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                ev = {m1_ready, 7'(c)};
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL t2_order: unexpected completion 0x%0h", ev);
                end else begin
                    want = exp_q.pop_front();
                    chk("t2_order", 64'(ev), 64'(want));
                end
                if (m0_ready) begin n0++; if (n0 == 2) m0_req = 1'b0; end
                if (m1_ready) begin n1++; if (n1 == 2) m1_req = 1'b0; end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        chk("t2_queue_empty", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        chk("t2_m1_rdata",   64'(m1_rdata), 64'(32'h600D_600D));
        chk("t2_m0_rdata",   64'(m0_rdata), 64'(0));
        chk("t2_err_pulses", 64'(err_cnt),  64'(0));
        repeat (2) @(negedge clk);

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
